// File: rtl/alarm_tone_gen.sv
// ---------------------------------------------------------------------------
// alarm_tone_gen
//
// Sample source for the alarm's I2S serializer. Produces 16-bit two's
// complement PCM samples of a beeping square-wave tone, one sample per
// request. All timing (tone half-period, beep length, gaps, pause) is counted
// in samples, so the audible rate is set entirely by the consumer.
//
// Pattern while alarm_on=1:
//   BEEPS x [ BEEP_ON tone samples, BEEP_OFF silent ] with the final gap
//   replaced by PAUSE silent samples, then repeat.
//
// Ports:
//   CLK          in   system clock
//   reset        in   asynchronous active-low reset
//   alarm_on     in   level, 1 = sound the alarm
//   sample_req   in   single-cycle request pulse from the I2S stage
//   sample       out  registered PCM sample (held between requests)
//   sample_valid out  single-cycle pulse, one cycle after each request
//   active       out  registered, 1 while the generator is not IDLE
//
// Handshake: sample_req is a one-cycle pulse with no back-pressure. Every
// request is answered with sample_valid=1 in the following cycle, with the
// new sample on `sample`. Back-to-back requests are each answered.
// ---------------------------------------------------------------------------
module alarm_tone_gen #(
   parameter int unsigned      TONE_HALF = 4,
   parameter logic [15:0]      AMPLITUDE = 16'h3000,
   parameter int unsigned      BEEP_ON   = 400,
   parameter int unsigned      BEEP_OFF  = 400,
   parameter int unsigned      BEEPS     = 3,
   parameter int unsigned      PAUSE     = 2000
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        alarm_on,
   input  logic        sample_req,
   output logic [15:0] sample,
   output logic        sample_valid,
   output logic        active
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TONE  = 2'd1,
      ST_GAP   = 2'd2,
      ST_PAUSE = 2'd3
   } state_e;

   localparam logic [15:0] HALF_LAST  = 16'(TONE_HALF - 1);
   localparam logic [15:0] ON_LAST    = 16'(BEEP_ON - 1);
   localparam logic [15:0] OFF_LAST   = 16'(BEEP_OFF - 1);
   localparam logic [15:0] BEEPS_LAST = 16'(BEEPS - 1);
   localparam logic [15:0] PAUSE_LAST = 16'(PAUSE - 1);
   localparam logic [15:0] AMP_NEG    = ~AMPLITUDE + 16'd1;

   // FSM state is kept in a named register so checkers can bind to it.
   state_e      state_q, state_d;
   logic [15:0] dur_cnt_q, dur_cnt_d;
   logic [15:0] half_cnt_q, half_cnt_d;
   logic [15:0] beep_cnt_q, beep_cnt_d;
   logic        phase_q, phase_d;      // 1 = positive half-period
   logic [15:0] sample_q, sample_d;
   logic        valid_q, valid_d;
   logic        active_q, active_d;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         dur_cnt_q  <= '0;
         half_cnt_q <= '0;
         beep_cnt_q <= '0;
         phase_q    <= 1'b1;
         sample_q   <= '0;
         valid_q    <= 1'b0;
         active_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         dur_cnt_q  <= dur_cnt_d;
         half_cnt_q <= half_cnt_d;
         beep_cnt_q <= beep_cnt_d;
         phase_q    <= phase_d;
         sample_q   <= sample_d;
         valid_q    <= valid_d;
         active_q   <= active_d;
      end
   end

   always_comb begin
      // Without a request everything holds, including the sample.
      state_d    = state_q;
      dur_cnt_d  = dur_cnt_q;
      half_cnt_d = half_cnt_q;
      beep_cnt_d = beep_cnt_q;
      phase_d    = phase_q;
      sample_d   = sample_q;
      valid_d    = 1'b0;
      active_d   = active_q;

      if (sample_req) begin
         valid_d  = 1'b1;
         sample_d = 16'h0000;

         if (state_q != ST_IDLE && !alarm_on) begin
            // Alarm released: silence and return to the power-on condition.
            state_d    = ST_IDLE;
            dur_cnt_d  = '0;
            half_cnt_d = '0;
            beep_cnt_d = '0;
            phase_d    = 1'b1;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (alarm_on) begin
                     state_d    = ST_TONE;
                     dur_cnt_d  = '0;
                     half_cnt_d = '0;
                     beep_cnt_d = '0;
                     phase_d    = 1'b1;
                  end
               end

               ST_TONE: begin
                  sample_d = phase_q ? AMPLITUDE : AMP_NEG;

                  if (half_cnt_q == HALF_LAST) begin
                     half_cnt_d = '0;
                     phase_d    = ~phase_q;
                  end else begin
                     half_cnt_d = half_cnt_q + 16'd1;
                  end

                  // End of beep overrides the half-period update so the
                  // next beep starts on a full positive half-period.
                  if (dur_cnt_q == ON_LAST) begin
                     dur_cnt_d  = '0;
                     half_cnt_d = '0;
                     phase_d    = 1'b1;
                     if (beep_cnt_q == BEEPS_LAST) begin
                        beep_cnt_d = '0;
                        state_d    = ST_PAUSE;
                     end else begin
                        beep_cnt_d = beep_cnt_q + 16'd1;
                        state_d    = ST_GAP;
                     end
                  end else begin
                     dur_cnt_d = dur_cnt_q + 16'd1;
                  end
               end

               ST_GAP: begin
                  if (dur_cnt_q == OFF_LAST) begin
                     dur_cnt_d = '0;
                     state_d   = ST_TONE;
                  end else begin
                     dur_cnt_d = dur_cnt_q + 16'd1;
                  end
               end

               ST_PAUSE: begin
                  if (dur_cnt_q == PAUSE_LAST) begin
                     dur_cnt_d = '0;
                     state_d   = ST_TONE;
                  end else begin
                     dur_cnt_d = dur_cnt_q + 16'd1;
                  end
               end

               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end

         active_d = (state_d != ST_IDLE);
      end
   end

   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign active       = active_q;

endmodule

// File: tb/tb_alarm_tone_gen.sv
// ---------------------------------------------------------------------------
// tb_alarm_tone_gen
//
// Self-checking bench for alarm_tone_gen with a shortened pattern
// (TONE_HALF=2, BEEP_ON=8, BEEP_OFF=4, BEEPS=2, PAUSE=6). The reference model
// places each request at a position within one pattern period and derives
// the sample from the beep/offset arithmetic.
// ---------------------------------------------------------------------------
module tb_alarm_tone_gen;

  localparam int unsigned    P_HALF  = 2;
  localparam logic [15:0]    P_AMP   = 16'h3000;
  localparam logic [15:0]    P_NEG   = 16'hD000;
  localparam int unsigned    P_ON    = 8;
  localparam int unsigned    P_OFF   = 4;
  localparam int unsigned    P_BEEPS = 2;
  localparam int unsigned    P_PAUSE = 6;
  localparam int unsigned    PERIOD  = P_BEEPS * P_ON + (P_BEEPS - 1) * P_OFF + P_PAUSE;

  logic        CLK;
  logic        reset;
  logic        alarm_on;
  logic        sample_req;
  logic [15:0] sample;
  logic        sample_valid;
  logic        active;

  int checks   = 0;
  int failures = 0;

  alarm_tone_gen #(
    .TONE_HALF (P_HALF),
    .AMPLITUDE (P_AMP),
    .BEEP_ON   (P_ON),
    .BEEP_OFF  (P_OFF),
    .BEEPS     (P_BEEPS),
    .PAUSE     (P_PAUSE)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .alarm_on     (alarm_on),
    .sample_req   (sample_req),
    .sample       (sample),
    .sample_valid (sample_valid),
    .active       (active)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model / scoreboard ----------------
  logic [15:0] exp_q[$];
  logic        exp_act_q[$];
  logic        m_running;
  int unsigned m_pos;
  logic [15:0] m_last;

  function automatic logic [15:0] pattern_value(input int unsigned p);
    int unsigned start;
    int unsigned off;
    for (int k = 0; k < int'(P_BEEPS); k++) begin
      start = k * (P_ON + P_OFF);
      if (p >= start && p < start + P_ON) begin
        off = p - start;
        return ((off / P_HALF) % 2 == 0) ? P_AMP : P_NEG;
      end
    end
    return 16'h0000;
  endfunction

  task automatic model_reset();
    m_running = 1'b0;
    m_pos     = 0;
    m_last    = 16'h0000;
    exp_q.delete();
    exp_act_q.delete();
  endtask

  task automatic model_step(input logic alarm);
    logic [15:0] s;
    s = 16'h0000;
    if (!m_running) begin
      if (alarm) begin
        m_running = 1'b1;
        m_pos     = 0;
      end
    end else if (!alarm) begin
      m_running = 1'b0;
    end else begin
      s     = pattern_value(m_pos);
      m_pos = (m_pos + 1) % PERIOD;
    end
    m_last = s;
    exp_q.push_back(s);
    exp_act_q.push_back(m_running);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; drives one cycle and returns the outputs seen at the
  // next negedge (after the edge that sampled the inputs).
  task automatic drive(input logic req, input logic alarm,
                       output logic [15:0] s, output logic v, output logic a);
    sample_req = req;
    alarm_on   = alarm;
    if (req) model_step(alarm);
    @(negedge CLK);
    s = sample;
    v = sample_valid;
    a = active;
    sample_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset      = 1'b0;
    alarm_on   = 1'b1;
    sample_req = 1'b1;
    model_reset();
    repeat (3) @(negedge CLK);
    checks++;
    if (sample !== 16'h0000) begin
      failures++; $display("FAIL reset_sample: got %h want 0000", sample);
    end
    checks++;
    if (sample_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b want 0", sample_valid);
    end
    checks++;
    if (active !== 1'b0) begin
      failures++; $display("FAIL reset_active: got %b want 0", active);
    end
    sample_req = 1'b0;
    alarm_on   = 1'b0;
    reset      = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_idle();
    logic [15:0] s; logic v, a, e_a;
    logic [15:0] e;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, s, v, a);
      e = exp_q.pop_front(); e_a = exp_act_q.pop_front();
      checks++;
      if (v !== 1'b1 || s !== e || a !== e_a) begin
        failures++;
        $display("FAIL idle_req[%0d]: got v=%b s=%h a=%b want v=1 s=%h a=%b", i, v, s, a, e, e_a);
      end
      drive(1'b0, 1'b0, s, v, a);
      checks++;
      if (v !== 1'b0 || a !== 1'b0) begin
        failures++;
        $display("FAIL idle_quiet[%0d]: got v=%b a=%b want v=0 a=0", i, v, a);
      end
    end
  endtask

  task automatic test_full_pattern();
    logic [15:0] s; logic v, a, e_a;
    logic [15:0] e;
    logic [15:0] got[40];
    int gap;
    for (int i = 0; i < 40; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) drive(1'b0, 1'b1, s, v, a);
      drive(1'b1, 1'b1, s, v, a);
      got[i] = s;
      e = exp_q.pop_front(); e_a = exp_act_q.pop_front();
      checks++;
      if (v !== 1'b1 || s !== e || a !== e_a) begin
        failures++;
        $display("FAIL pattern[%0d]: got v=%b s=%h a=%b want v=1 s=%h a=%b", i, v, s, a, e, e_a);
      end
    end
    // Fixed anchor points of the shortened pattern.
    checks++;
    if (got[0] !== 16'h0000 || got[1] !== 16'h3000 || got[3] !== 16'hD000 ||
        got[9] !== 16'h0000 || got[13] !== 16'h3000 || got[21] !== 16'h0000 ||
        got[27] !== 16'h3000 || got[29] !== 16'hD000) begin
      failures++;
      $display("FAIL pattern_anchor: got %h %h %h %h %h %h %h %h want 0000 3000 d000 0000 3000 0000 3000 d000",
               got[0], got[1], got[3], got[9], got[13], got[21], got[27], got[29]);
    end
  endtask

  task automatic test_alarm_off_mid_tone();
    logic [15:0] s; logic v, a, e_a;
    logic [15:0] e;
    logic [15:0] want[4];
    drive(1'b1, 1'b0, s, v, a);               // force IDLE
    void'(exp_q.pop_front()); void'(exp_act_q.pop_front());
    drive(1'b1, 1'b1, s, v, a);               // idle -> tone
    void'(exp_q.pop_front()); void'(exp_act_q.pop_front());
    repeat (3) begin
      drive(1'b1, 1'b1, s, v, a);
      void'(exp_q.pop_front()); void'(exp_act_q.pop_front());
    end
    drive(1'b1, 1'b0, s, v, a);
    e = exp_q.pop_front(); e_a = exp_act_q.pop_front();
    checks++;
    if (s !== e || a !== e_a || s !== 16'h0000 || a !== 1'b0) begin
      failures++;
      $display("FAIL alarm_off: got s=%h a=%b want s=0000 a=0", s, a);
    end
    want[0] = 16'h0000; want[1] = 16'h3000; want[2] = 16'h3000; want[3] = 16'hD000;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, s, v, a);
      e = exp_q.pop_front(); e_a = exp_act_q.pop_front();
      checks++;
      if (s !== e || s !== want[i] || a !== 1'b1 || v !== 1'b1) begin
        failures++;
        $display("FAIL rearm[%0d]: got v=%b s=%h a=%b want v=1 s=%h a=1", i, v, s, a, want[i]);
      end
    end
  endtask

  task automatic test_async_reset_gap();
    logic [15:0] s; logic v, a, e_a;
    logic [15:0] e;
    drive(1'b1, 1'b0, s, v, a);
    // idle->tone, 8 tone samples, 2 gap samples: now inside GAP
    repeat (11) drive(1'b1, 1'b1, s, v, a);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (sample !== 16'h0000 || active !== 1'b0 || sample_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got s=%h a=%b v=%b want s=0000 a=0 v=0", sample, active, sample_valid);
    end
    model_reset();
    @(negedge CLK);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, s, v, a);
      e = exp_q.pop_front(); e_a = exp_act_q.pop_front();
      checks++;
      if (v !== 1'b1 || s !== e || a !== e_a) begin
        failures++;
        $display("FAIL post_reset[%0d]: got v=%b s=%h a=%b want v=1 s=%h a=%b", i, v, s, a, e, e_a);
      end
    end
  endtask

  task automatic test_spacing();
    logic [15:0] s; logic v, a, e_a;
    logic [15:0] e;
    int bad_v, bad_s;
    bad_v = 0; bad_s = 0;
    for (int i = 0; i < 1000; i++) begin
      drive(1'b0, 1'b1, s, v, a);
      if (v !== 1'b0) bad_v++;
      if (s !== m_last || a !== m_running) bad_s++;
    end
    checks++;
    if (bad_v != 0) begin
      failures++; $display("FAIL spacing_valid: got %0d stray valids want 0", bad_v);
    end
    checks++;
    if (bad_s != 0) begin
      failures++; $display("FAIL spacing_hold: got %0d changed cycles want 0", bad_s);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, s, v, a);
      e = exp_q.pop_front(); e_a = exp_act_q.pop_front();
      checks++;
      if (v !== 1'b1 || s !== e || a !== e_a) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got v=%b s=%h a=%b want v=1 s=%h a=%b", i, v, s, a, e, e_a);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] s; logic v, a, e_a;
    logic [15:0] e;
    logic req, alarm;
    int errs;
    errs = 0;
    alarm = 1'b1;
    for (int i = 0; i < 300; i++) begin
      req = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) alarm = ~alarm;
      drive(req, alarm, s, v, a);
      if (req) begin
        e = exp_q.pop_front(); e_a = exp_act_q.pop_front();
        if (v !== 1'b1 || s !== e || a !== e_a) begin
          errs++;
          if (errs <= 5)
            $display("FAIL random[%0d]: got v=%b s=%h a=%b want v=1 s=%h a=%b", i, v, s, a, e, e_a);
        end
      end else if (v !== 1'b0 || s !== m_last) begin
        errs++;
        if (errs <= 5)
          $display("FAIL random_hold[%0d]: got v=%b s=%h want v=0 s=%h", i, v, s, m_last);
      end
    end
    checks++;
    if (errs != 0) begin
      failures++; $display("FAIL random_total: got %0d errors want 0", errs);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset      = 1'b1;
    alarm_on   = 1'b0;
    sample_req = 1'b0;
    model_reset();
    @(negedge CLK);
    test_reset();
    test_idle();
    test_full_pattern();
    test_alarm_off_mid_tone();
    test_async_reset_gap();
    test_spacing();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
